// File: rtl/y86_mem_arbiter_if.sv
// rtl/y86_mem_arbiter_if.sv - requester and memory bus bundle for y86_mem_arbiter
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1   requester commands
//   ack0/ack1, rdata0/rdata1, gnt0/gnt1              requester completion and ownership
//   mem_A, mem_out, mem_WE, mem_RE, mem_in           single-ported memory side
// Modports: slave = arbiter view, master = requesters plus memory view.
interface y86_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          gnt0, gnt1;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_out;
  logic          mem_WE, mem_RE;
  logic [DW-1:0] mem_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
    output ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_A, mem_out, mem_WE, mem_RE
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_in,
    input  ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_A, mem_out, mem_WE, mem_RE
  );
endinterface

// File: rtl/y86_mem_arbiter.sv
// rtl/y86_mem_arbiter.sv - two-port round-robin arbiter in front of one single-ported memory
// Ports:
//   clk   clock
//   rst   synchronous active-high reset; aborts any transaction in flight
//   bus   y86_mem_arbiter_if.slave: per-port req/we/addr/wdata in, ack/rdata/gnt out;
//         memory side mem_A/mem_out/mem_WE/mem_RE out, mem_in in
// Parameters: AW/DW bus widths, MEM_LAT read latency in cycles (1..15).
module y86_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  y86_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          port_q, port_d;         // port owning the transaction in flight
  logic          we_q, we_d;             // latched command direction
  logic          last_gnt_q, last_gnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_out_q, mem_out_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // On a tie the port that did not win last time gets the memory.
  logic          sel;
  logic          sel_we;
  assign sel    = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
  assign sel_we = sel ? bus.we1 : bus.we0;

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    mem_a_d    = '0;
    mem_out_d  = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // The command is captured straight into the strobe registers, so
          // later changes on the request inputs cannot reach the memory.
          port_d     = sel;
          last_gnt_d = sel;
          we_d       = sel_we;
          mem_a_d    = sel ? bus.addr1 : bus.addr0;
          mem_out_d  = sel_we ? (sel ? bus.wdata1 : bus.wdata0) : '0;
          mem_we_d   = sel_we;
          mem_re_d   = ~sel_we;
          gnt0_d     = ~sel;
          gnt1_d     = sel;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (port_q) rdata1_d = bus.mem_in;
          else        rdata0_d = bus.mem_in;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= 4'd0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_out_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_a_q    <= mem_a_d;
      mem_out_q  <= mem_out_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.mem_A   = mem_a_q;
  assign bus.mem_out = mem_out_q;
  assign bus.mem_WE  = mem_we_q;
  assign bus.mem_RE  = mem_re_q;
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb/tb_y86_mem_arbiter.sv - bench for y86_mem_arbiter at MEM_LAT 2, 4 and 1
module tb_y86_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  y86_mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
  y86_mem_arbiter_if #(.AW(AW), .DW(DW)) b4 ();
  y86_mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();

  y86_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  y86_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  y86_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory devices: read data is only valid in the exact cycle MEM_LAT after the strobe.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  initial begin
    int due = -1;
    logic [31:0] ra = '0;
    forever begin
      @(negedge clk);
      if (b2.mem_WE) dev_mem[b2.mem_A] = b2.mem_out;
      if (b2.mem_RE) begin due = cyc + 2; ra = b2.mem_A; end
      b2.mem_in = (cyc == due) ? dev_rd(ra) : (32'hBAD00000 ^ 32'(cyc));
    end
  end

  initial begin
    int due = -1;
    logic [31:0] ra = '0;
    forever begin
      @(negedge clk);
      if (b4.mem_RE) begin due = cyc + 4; ra = b4.mem_A; end
      b4.mem_in = (cyc == due) ? init_val(ra) : (32'hBAD40000 ^ 32'(cyc));
    end
  end

  initial begin
    int due = -1;
    logic [31:0] ra = '0;
    forever begin
      @(negedge clk);
      if (b1.mem_RE) begin due = cyc + 1; ra = b1.mem_A; end
      b1.mem_in = (cyc == due) ? init_val(ra) : (32'hBAD10000 ^ 32'(cyc));
    end
  end

  task automatic zero_inputs();
    b2.req0 = 0; b2.req1 = 0; b2.we0 = 0; b2.we1 = 0;
    b2.addr0 = '0; b2.addr1 = '0; b2.wdata0 = '0; b2.wdata1 = '0;
    b4.req0 = 0; b4.req1 = 0; b4.we0 = 0; b4.we1 = 0;
    b4.addr0 = '0; b4.addr1 = '0; b4.wdata0 = '0; b4.wdata1 = '0;
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    zero_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drive2(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin b2.req1 = 1; b2.we1 = we; b2.addr1 = a; b2.wdata1 = d; end
    else   begin b2.req0 = 1; b2.we0 = we; b2.addr0 = a; b2.wdata0 = d; end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  // One isolated transaction on the MEM_LAT=2 instance; the command inputs are
  // scrambled right after the grant edge to show they were latched.
  task automatic run_vec(input int idx, input vec_t v);
    int strobe_at = -1;
    int ack_at    = -1;
    int gcyc      = 0;
    int wrong     = 0;
    logic [31:0] own_before, other_before, rd;
    own_before   = v.port ? b2.rdata1 : b2.rdata0;
    other_before = v.port ? b2.rdata0 : b2.rdata1;
    rd = '0;
    @(negedge clk);
    drive2(v.port, v.we, v.addr, v.wdata);
    @(posedge clk);
    #1;
    drive2(v.port, ~v.we, v.addr ^ 32'h89, ~v.wdata);
    for (int n = 1; n <= 12 && ack_at < 0; n++) begin
      @(negedge clk);
      if (b2.mem_WE || b2.mem_RE) begin
        strobe_at = n;
        chk($sformatf("vec%0d_mem_A", idx), b2.mem_A, v.addr);
        chk($sformatf("vec%0d_strobe", idx), {b2.mem_WE, b2.mem_RE}, v.we ? 2'b10 : 2'b01);
        chk($sformatf("vec%0d_mem_out", idx), b2.mem_out, v.we ? v.wdata : 32'h0);
      end else if (b2.mem_A != 0 || b2.mem_out != 0) begin
        wrong++;
      end
      if (v.port ? b2.gnt1 : b2.gnt0) gcyc++;
      if (v.port ? (b2.gnt0 || b2.ack0) : (b2.gnt1 || b2.ack1)) wrong++;
      if (v.port ? b2.ack1 : b2.ack0) begin
        ack_at = n;
        rd = v.port ? b2.rdata1 : b2.rdata0;
        zero_inputs();
      end
    end
    zero_inputs();
    if (v.we) ref_mem[v.addr] = v.wdata;
    chk($sformatf("vec%0d_strobe_cycle", idx), strobe_at, 1);
    chk($sformatf("vec%0d_ack_cycle", idx), ack_at, v.we ? 2 : 4);
    chk($sformatf("vec%0d_gnt_cycles", idx), gcyc, v.we ? 2 : 4);
    chk($sformatf("vec%0d_rdata", idx), rd, v.we ? own_before : v.exp_rdata);
    chk($sformatf("vec%0d_other_port", idx), wrong, 0);
    chk($sformatf("vec%0d_other_rdata", idx), v.port ? b2.rdata0 : b2.rdata1, other_before);
  endtask

  // Randomised traffic, checked against a transaction-level model.
  bit          pend [2];
  bit          pwe  [2];
  logic [31:0] paddr[2];
  logic [31:0] pdata[2];
  int          others_since[2];
  int          comp[2];
  bit          rq_done[2];
  localparam int NTX = 25;

  task automatic requester(input bit p);
    for (int k = 0; k < NTX; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pwe[p]          = 1'($urandom_range(0, 1));
      paddr[p]        = 32'(4 * $urandom_range(0, 15));
      pdata[p]        = $urandom;
      others_since[p] = 0;
      pend[p]         = 1;
      drive2(p, pwe[p], paddr[p], pdata[p]);
      for (int w = 0; w < 60 && pend[p]; w++) @(negedge clk);
      if (pend[p]) begin
        chk($sformatf("rnd_timeout_port%0d", p), 0, 1);
        pend[p] = 0;
        if (p) b2.req1 = 0; else b2.req0 = 0;
      end
    end
    rq_done[p] = 1;
  endtask

  task automatic monitor();
    int  strobe_n = -100;
    bit  strobe_p = 0;
    int  overlap  = 0;
    bit  sp;
    for (int n = 0; n < 4000 && !(rq_done[0] && rq_done[1]); n++) begin
      @(negedge clk);
      if (b2.gnt0 && b2.gnt1) overlap++;
      if (b2.mem_WE || b2.mem_RE) begin
        sp = b2.gnt1;
        chk("rnd_strobe_pending", pend[sp], 1);
        chk("rnd_strobe_addr", b2.mem_A, paddr[sp]);
        chk("rnd_strobe_kind", {b2.mem_WE, b2.mem_RE}, pwe[sp] ? 2'b10 : 2'b01);
        if (pwe[sp]) chk("rnd_strobe_wdata", b2.mem_out, pdata[sp]);
        strobe_n = n;
        strobe_p = sp;
      end
      for (int p = 0; p < 2; p++) begin
        if (p == 1 ? b2.ack1 : b2.ack0) begin
          chk("rnd_ack_pending", pend[p], 1);
          chk("rnd_ack_port", p, strobe_p);
          chk("rnd_latency", n - strobe_n, pwe[p] ? 1 : 3);
          if (pwe[p]) ref_mem[paddr[p]] = pdata[p];
          else chk("rnd_rdata", p == 1 ? b2.rdata1 : b2.rdata0, ref_rd(paddr[p]));
          chk("rnd_fairness", others_since[p] <= 1, 1);
          if (pend[1-p]) others_since[1-p]++;
          comp[p]++;
          pend[p] = 0;
          if (p == 1) b2.req1 = 0; else b2.req0 = 0;
        end
      end
    end
    chk("rnd_gnt_overlap", overlap, 0);
    chk("rnd_done", rq_done[0] && rq_done[1], 1);
  endtask

  vec_t vecs[6];

  initial begin
    int nacks, last_strobe, overlap, acks_seen, re_n, ack_n;
    logic [31:0] rd;

    vecs[0] = '{port: 0, we: 0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'h1234ABCD};
    vecs[1] = '{port: 1, we: 1, addr: 32'h20, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
    vecs[2] = '{port: 1, we: 0, addr: 32'h20, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[3] = '{port: 0, we: 1, addr: 32'h30, wdata: 32'hCAFEF00D, exp_rdata: 32'h0};
    vecs[4] = '{port: 0, we: 0, addr: 32'h30, wdata: 32'h0,        exp_rdata: 32'hCAFEF00D};
    vecs[5] = '{port: 1, we: 0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'h1234ABCD};

    dev_mem[32'h10] = 32'h1234ABCD;
    ref_mem[32'h10] = 32'h1234ABCD;

    zero_inputs();
    do_reset();

    chk("reset_ctl", {b2.ack0, b2.ack1, b2.gnt0, b2.gnt1, b2.mem_WE, b2.mem_RE}, 6'b0);
    chk("reset_mem_A", b2.mem_A, 32'h0);
    chk("reset_mem_out", b2.mem_out, 32'h0);
    chk("reset_rdata", {b2.rdata0, b2.rdata1}, 64'h0);

    // Both ports held from reset: expect 0,1,0,1 with strobes 3+MEM_LAT apart.
    @(negedge clk);
    drive2(0, 0, 32'h40, 32'h0);
    drive2(1, 0, 32'h44, 32'h0);
    nacks = 0; last_strobe = -1; overlap = 0;
    for (int n = 0; n < 60 && nacks < 4; n++) begin
      @(negedge clk);
      if (b2.gnt0 && b2.gnt1) overlap++;
      if (b2.mem_RE) begin
        if (last_strobe >= 0) chk($sformatf("tie_spacing%0d", nacks), n - last_strobe, 5);
        last_strobe = n;
      end
      if (b2.ack0 || b2.ack1) begin
        chk($sformatf("tie_order%0d", nacks), b2.ack1, nacks % 2);
        chk($sformatf("tie_rdata%0d", nacks), b2.ack1 ? b2.rdata1 : b2.rdata0,
            b2.ack1 ? init_val(32'h44) : init_val(32'h40));
        nacks++;
      end
    end
    zero_inputs();
    chk("tie_acks", nacks, 4);
    chk("tie_gnt_overlap", overlap, 0);

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    fork
      requester(0);
      requester(1);
      monitor();
    join
    chk("rnd_count0", comp[0], NTX);
    chk("rnd_count1", comp[1], NTX);
    zero_inputs();

    // MEM_LAT=4: reset lands in WAIT; nothing completes and the next tie goes to port 0.
    @(negedge clk);
    b4.req0 = 1; b4.we0 = 0; b4.addr0 = 32'h50;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_ctl", {b4.ack0, b4.ack1, b4.gnt0, b4.gnt1, b4.mem_WE, b4.mem_RE}, 6'b0);
    chk("abort_bus", {b4.mem_A, b4.mem_out}, 64'h0);
    chk("abort_rdata", {b4.rdata0, b4.rdata1}, 64'h0);
    rst = 0;
    b4.req0 = 0;
    acks_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (b4.ack0 || b4.ack1) acks_seen++;
    end
    chk("abort_no_ack", acks_seen, 0);
    b4.req0 = 1; b4.we0 = 0; b4.addr0 = 32'h54;
    b4.req1 = 1; b4.we1 = 0; b4.addr1 = 32'h58;
    @(negedge clk);
    chk("abort_regrant", {b4.gnt0, b4.gnt1, b4.mem_RE}, 3'b101);
    ack_n = -1; rd = '0;
    for (int n = 2; n <= 12 && ack_n < 0; n++) begin
      @(negedge clk);
      if (b4.ack0) begin ack_n = n; rd = b4.rdata0; zero_inputs(); end
    end
    zero_inputs();
    chk("lat4_ack_cycle", ack_n, 6);
    chk("lat4_rdata", rd, init_val(32'h54));

    // MEM_LAT=1: WAIT is a single cycle and captures in it.
    @(negedge clk);
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 32'h4;
    re_n = -1; ack_n = -1; rd = '0;
    for (int n = 1; n <= 10 && ack_n < 0; n++) begin
      @(negedge clk);
      if (b1.mem_RE) begin re_n = n; chk("lat1_mem_A", b1.mem_A, 32'h4); end
      if (b1.ack0) begin ack_n = n; rd = b1.rdata0; zero_inputs(); end
    end
    zero_inputs();
    chk("lat1_strobe_cycle", re_n, 1);
    chk("lat1_ack_cycle", ack_n, 3);
    chk("lat1_rdata", rd, init_val(32'h4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
